requantize_scheduler: RTL and testbench

Shares one SIZE-lane 9-bit→8-bit requantize datapath among NREQ requesters, typically the accumulator drains of parallel convolution layer engines. It runs a round-robin arbiter with valid/ready handshakes on every requester port and holds a runtime-programmable signed shift per requester. The shift/saturate pipeline is two stages and stalls under output backpressure without losing data. It sits between the layer accumulators and the 8-bit activation buffers.

---
 rtl/requantize_scheduler_if.sv | 28 ++
 rtl/requantize_scheduler.sv | 105 ++++++++++
 tb/tb_requantize_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/requantize_scheduler_if.sv
// requantize_scheduler_if: requester, config and output ports of the shared requantizer
interface requantize_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int SIZE    = 4,
    parameter int SHIFT_W = 4,
    parameter int TAG_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*9*SIZE-1:0] req_data;
    logic                   cfg_we;
    logic [TAG_W-1:0]       cfg_idx;
    logic [SHIFT_W-1:0]     cfg_shift;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*SIZE-1:0]      out_data;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output req_valid, req_data, cfg_we, cfg_idx, cfg_shift, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  req_valid, req_data, cfg_we, cfg_idx, cfg_shift, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/requantize_scheduler.sv
// requantize_scheduler: round-robin shared 9->8 bit requantizer with per-requester shift
module requantize_scheduler #(
    parameter int NREQ    = 4,
    parameter int SIZE    = 4,
    parameter int SHIFT_W = 4,
    parameter int TAG_W   = $clog2(NREQ)
) (
    input logic clock,
    input logic reset,
    requantize_scheduler_if.slave bus
);
    localparam int W   = 9 * SIZE;
    localparam int EXT = 9 + 2 ** (SHIFT_W - 1);
    localparam logic signed [EXT-1:0] MAXV = EXT'(127);
    localparam logic signed [EXT-1:0] MINV = EXT'(-128);

    logic [SHIFT_W-1:0]    shift_tab [NREQ];
    logic [TAG_W-1:0]      ptr, off, grant;
    logic [TAG_W:0]        sum;
    logic [NREQ-1:0]       rot;
    logic                  grant_valid, accept, adv1, adv2;
    logic [W-1:0]          word, s1_data;
    logic [SHIFT_W-1:0]    gshift, s1_shift, mag;
    logic [TAG_W-1:0]      s1_tag, out_tag;
    logic                  s1_valid, out_valid;
    logic [8*SIZE-1:0]     result, out_data;
    logic signed [EXT-1:0] wide [SIZE];

    assign adv2   = !out_valid || bus.out_ready;
    assign adv1   = !s1_valid || adv2;
    assign accept = grant_valid && adv1 && !reset;

    // Rotate valids so bit 0 is the current priority holder; lowest set bit wins.
    assign rot = NREQ'({bus.req_valid, bus.req_valid} >> ptr);

    always_comb begin
        grant_valid = 1'b0;
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) begin
                grant_valid = 1'b1;
                off = TAG_W'(i);
            end
    end

    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign grant = (sum >= (TAG_W+1)'(NREQ)) ? TAG_W'(sum - (TAG_W+1)'(NREQ)) : TAG_W'(sum);

    always_comb begin
        word = '0;
        gshift = '0;
        for (int r = 0; r < NREQ; r++)
            if (grant == TAG_W'(r)) begin
                word = bus.req_data[W*r +: W];
                gshift = shift_tab[r];
            end
    end

    assign bus.req_ready = accept ? (NREQ'(1) << grant) : '0;

    assign mag = s1_shift[SHIFT_W-1] ? -s1_shift : s1_shift;

    always_comb begin
        result = '0;
        for (int i = 0; i < SIZE; i++) begin
            wide[i] = s1_shift[SHIFT_W-1] ? EXT'(signed'(s1_data[9*i +: 9])) >>> mag
                                          : EXT'(signed'(s1_data[9*i +: 9])) <<< mag;
            result[8*i +: 8] = (wide[i] > MAXV) ? 8'h7f : (wide[i] < MINV) ? 8'h80 : wide[i][7:0];
        end
    end

    // The shift is captured with the word so later config writes never touch in-flight data.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
            s1_valid <= 1'b0;
            s1_data <= '0;
            s1_tag <= '0;
            s1_shift <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_tag <= '0;
            for (int r = 0; r < NREQ; r++) shift_tab[r] <= '0;
        end else begin
            if (adv1) s1_valid <= accept;
            if (accept) begin
                s1_data <= word;
                s1_tag <= grant;
                s1_shift <= gshift;
                ptr <= (grant == TAG_W'(NREQ - 1)) ? '0 : grant + TAG_W'(1);
            end
            if (adv2) begin
                out_valid <= s1_valid;
                out_data <= result;
                out_tag <= s1_tag;
            end
            for (int r = 0; r < NREQ; r++)
                if (bus.cfg_we && bus.cfg_idx == TAG_W'(r)) shift_tab[r] <= bus.cfg_shift;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_tag   = out_tag;
endmodule

// File: tb/tb_requantize_scheduler.sv
// tb_requantize_scheduler: randomized and directed checks against an arithmetic reference model
module tb_requantize_scheduler;
    localparam int NREQ = 4, SIZE = 4, SHIFT_W = 4, TAG_W = 2, W = 9 * SIZE;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    requantize_scheduler_if #(.NREQ(NREQ), .SIZE(SIZE), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus();

    requantize_scheduler #(.NREQ(NREQ), .SIZE(SIZE), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int m_shift [NREQ];
    int m_ptr, m_s1tag, m_s1sh, m_otag, cfg_val;
    bit m_s1v, m_ov;
    logic [W-1:0] m_s1d;
    logic [8*SIZE-1:0] m_od;

    logic [NREQ-1:0] obs_ready;
    logic obs_valid;
    logic [8*SIZE-1:0] obs_data;
    logic [TAG_W-1:0] obs_tag;
    int out_tags[$];
    logic [8*SIZE-1:0] out_words[$];
    logic [W-1:0] bp_q[$];
    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8*SIZE-1:0] requant(logic [W-1:0] w, int s);
        logic [8*SIZE-1:0] o;
        int v, r, d;
        o = '0;
        for (int i = 0; i < SIZE; i++) begin
            v = int'(w[9*i +: 9]);
            if (v > 255) v -= 512;
            if (s >= 0) r = v * (1 << s);
            else begin
                d = 1 << (-s);
                r = (v >= 0) ? v / d : -((-v + d - 1) / d);
            end
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            o[8*i +: 8] = 8'(r);
        end
        return o;
    endfunction

    function automatic logic [W-1:0] wd(int a, int b, int c, int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic rand_data();
        for (int r = 0; r < NREQ; r++) bus.req_data[W*r +: W] = {4'($urandom), 32'($urandom)};
    endtask

    task automatic model_reset();
        m_ptr = 0; m_s1v = 0; m_ov = 0; m_od = '0; m_otag = 0;
        m_s1tag = 0; m_s1sh = 0; m_s1d = '0;
        for (int r = 0; r < NREQ; r++) m_shift[r] = 0;
    endtask

    task automatic step();
        int g;
        bit a1, a2;
        logic [NREQ-1:0] er;
        @(negedge clock);
        a2 = !m_ov || bus.out_ready;
        a1 = !m_s1v || a2;
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        er = (g >= 0 && a1 && !reset) ? (NREQ'(1) << g) : '0;
        check("ready", bus.req_ready, er);
        check("out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
            check("out_data", bus.out_data, m_od);
            check("out_tag", bus.out_tag, m_otag);
        end
        obs_ready = bus.req_ready;
        obs_valid = bus.out_valid;
        obs_data = bus.out_data;
        obs_tag = bus.out_tag;
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
            out_tags.push_back(int'(bus.out_tag));
            out_words.push_back(bus.out_data);
        end
        @(posedge clock);
        if (reset) model_reset();
        else begin
            if (a2) begin
                m_ov = m_s1v;
                m_otag = m_s1tag;
                m_od = requant(m_s1d, m_s1sh);
            end
            if (a1) begin
                m_s1v = (g >= 0);
                if (g >= 0) begin
                    m_s1tag = g;
                    m_s1d = bus.req_data[W*g +: W];
                    m_s1sh = m_shift[g];
                    m_ptr = (g + 1) % NREQ;
                end
            end
            if (bus.cfg_we) m_shift[bus.cfg_idx] = cfg_val;
        end
        #1;
    endtask

    task automatic cfg(int idx, int v);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = TAG_W'(idx);
        cfg_val = v;
        bus.cfg_shift = SHIFT_W'(v);
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic one(int r, logic [W-1:0] w, logic [31:0] exp, string tag, bit we = 1'b0, int sh = 0);
        bus.req_valid = '0;
        bus.req_valid[r] = 1'b1;
        bus.req_data[W*r +: W] = w;
        if (we) begin
            bus.cfg_we = 1'b1;
            bus.cfg_idx = TAG_W'(r);
            cfg_val = sh;
            bus.cfg_shift = SHIFT_W'(sh);
        end
        step();
        bus.cfg_we = 1'b0;
        bus.req_valid = '0;
        check({tag, "_ready"}, obs_ready[r], 1);
        step();
        check({tag, "_lat"}, obs_valid, 0);
        step();
        check({tag, "_valid"}, obs_valid, 1);
        check({tag, "_data"}, obs_data, exp);
        check({tag, "_tag"}, obs_tag, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, hold;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b1;
        cfg_val = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        step();
        check("rst_data", obs_data, 0);
        check("rst_tag", obs_tag, 0);
        check("rst_ready", obs_ready, 0);
        reset = 1'b0;

        one(0, wd(100, 255, -200, -1), 32'hFF807F64, "pass");
        cfg(1, -2);
        one(1, wd(100, -3, -256, 7), 32'h01C0FF19, "rsh2");
        cfg(1, -1);
        one(1, wd(-3, 0, 0, 0), 32'h000000FE, "rsh1");
        cfg(2, 2);
        one(2, wd(40, -32, -33, 31), 32'h7C80807F, "lsh2");
        cfg(2, 1);
        one(2, wd(-64, 50, 0, 0), 32'h00006480, "lsh1");
        one(0, wd(100, 0, 0, 0), 32'h00000064, "race_old", 1'b1, -1);
        one(0, wd(100, 0, 0, 0), 32'h00000032, "race_new");

        reset = 1'b1; step(); reset = 1'b0;
        out_tags.delete(); out_words.delete();
        bus.req_valid = 4'hF;
        repeat (8) begin rand_data(); step(); end
        check("rr_count", out_tags.size() >= 6, 1);
        for (int i = 0; i < 6 && i < out_tags.size(); i++) check("rr_tag", out_tags[i], rr_exp[i]);
        bus.req_valid = 4'b1101;
        repeat (8) begin
            rand_data();
            step();
            check("rr_bubble", obs_valid, 1);
            check("rr_skip", obs_tag == 2'd1, 0);
        end
        bus.req_valid = '0;

        reset = 1'b1; step(); reset = 1'b0;
        out_tags.delete(); out_words.delete(); bp_q.delete();
        for (int i = 0; i < 6; i++)
            bp_q.push_back(wd(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128));
        acc = 0;
        hold = -1;
        bus.req_valid = 4'b1000;
        bus.req_data[W*3 +: W] = bp_q[0];
        for (int c = 0; c < 40 && out_words.size() < 6; c++) begin
            step();
            if (obs_ready[3]) begin
                acc++;
                if (acc < 6) bus.req_data[W*3 +: W] = bp_q[acc];
                else bus.req_valid = '0;
            end
            check("bp_inflight", (acc - out_words.size()) <= 2, 1);
            if (obs_valid && hold < 0) hold = 3;
            if (hold > 0) begin bus.out_ready = 1'b0; hold--; end
            else bus.out_ready = 1'b1;
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        check("bp_count", out_words.size(), 6);
        for (int i = 0; i < 6 && i < out_words.size(); i++) begin
            check("bp_word", out_words[i], requant(bp_q[i], 0));
            check("bp_tag", out_tags[i], 3);
        end

        cfg(2, 1);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        rand_data();
        repeat (3) step();
        check("full_valid", obs_valid, 1);
        reset = 1'b1; step(); reset = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        step();
        check("rst_flush", obs_valid, 0);
        step();
        check("rst_flush2", obs_valid, 0);
        one(2, wd(100, 255, -200, -1), 32'hFF807F64, "rst_shift");

        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = NREQ'($urandom);
            rand_data();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_we = ($urandom_range(0, 7) == 0);
            bus.cfg_idx = TAG_W'($urandom);
            cfg_val = int'($urandom_range(0, 15)) - 8;
            bus.cfg_shift = SHIFT_W'(cfg_val);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        bus.cfg_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
